// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and defaults for the fast-RAM refresh arbiter
// Purpose: refresh FSM state encoding, timing defaults, idle strobe levels.
// Ports: none (package).
package ram_pkg;

   localparam int REF_INTERVAL_DFLT = 218;
   localparam int MAX_PENDING_DFLT  = 4;
   localparam int T_RAS_DFLT        = 3;
   localparam int T_RP_DFLT         = 2;

   // Active-low strobes: all ones means negated.
   localparam logic [1:0] RAS_IDLE = 2'b11;
   localparam logic [3:0] CAS_IDLE = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CSR  = 2'd1,
      RAS  = 2'd2,
      PRE  = 2'd3
   } ref_state_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/refresh_timer.sv
// rtl/refresh_timer.sv - refresh interval tick and saturating pending-refresh count
// Purpose: free-running interval counter raising a one-cycle tick, and the queue
//          depth of refreshes owed to the DRAM.
// Ports:  clk_i, rst_ni      clock, async active-low reset
//         complete_i         last precharge cycle of a refresh
//         tick_o             one-cycle interval tick
//         pending_o          refreshes owed, 0..MAX_PENDING
//         urgent_o           pending_o at MAX_PENDING
//         overrun_o          sticky: a tick was dropped at saturation
module refresh_timer
   import ram_pkg::*;
#(
   parameter int REF_INTERVAL = REF_INTERVAL_DFLT,
   parameter int MAX_PENDING  = MAX_PENDING_DFLT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       complete_i,
   output logic       tick_o,
   output logic [2:0] pending_o,
   output logic       urgent_o,
   output logic       overrun_o
);

   localparam int            IW     = $clog2(REF_INTERVAL);
   localparam logic [IW-1:0] I_LAST = IW'(REF_INTERVAL - 1);
   localparam logic [2:0]    P_MAX  = 3'(MAX_PENDING);

   logic [IW-1:0] icnt_q, icnt_d;
   logic [2:0]    pend_q, pend_d;
   logic          ovr_q, ovr_d;

   always_comb begin
      tick_o = (icnt_q == I_LAST);
      icnt_d = tick_o ? '0 : icnt_q + IW'(1);
      pend_d = pend_q;
      ovr_d  = ovr_q;
      // A tick and a completion in the same cycle cancel out.
      if (tick_o && !complete_i) begin
         if (pend_q == P_MAX) begin
            ovr_d = 1'b1;
         end else begin
            pend_d = pend_q + 3'd1;
         end
      end else if (complete_i && !tick_o && (pend_q != 3'd0)) begin
         pend_d = pend_q - 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         icnt_q <= '0;
         pend_q <= 3'd0;
         ovr_q  <= 1'b0;
      end else begin
         icnt_q <= icnt_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
      end
   end

   assign pending_o = pend_q;
   assign urgent_o  = (pend_q == P_MAX);
   assign overrun_o = ovr_q;

endmodule

// File: rtl/dram_refresh_arbiter.sv
// rtl/dram_refresh_arbiter.sv - CAS-before-RAS refresh arbiter beside fastmem
// Purpose: decides when refresh owns the DRAM RAS/CAS pins and stalls fastmem.
// Ports:  clkcpu_i, reset_ni  CPU clock, async active-low reset
//         as20_i              CPU address strobe (active low)
//         ram_sel_i           fast-RAM decode (active low)
//         ram_idle_i          fastmem idle with strobes negated
//         cpu_hold_o          fastmem must not start / must stall before RAS
//         ref_active_o        refresh owns the pins (mux select)
//         ref_ras_o/ref_cas_o active-low refresh strobes
//         pending_o           queued refresh count
//         overrun_o           sticky lost-request flag
module dram_refresh_arbiter
   import ram_pkg::*;
#(
   parameter int REF_INTERVAL = REF_INTERVAL_DFLT,
   parameter int MAX_PENDING  = MAX_PENDING_DFLT,
   parameter int T_RAS        = T_RAS_DFLT,
   parameter int T_RP         = T_RP_DFLT
) (
   input  logic       clkcpu_i,
   input  logic       reset_ni,
   input  logic       as20_i,
   input  logic       ram_sel_i,
   input  logic       ram_idle_i,
   output logic       cpu_hold_o,
   output logic       ref_active_o,
   output logic [1:0] ref_ras_o,
   output logic [3:0] ref_cas_o,
   output logic [2:0] pending_o,
   output logic       overrun_o
);

   localparam int            CW       = $clog2(max2(T_RAS, T_RP) + 1);
   localparam logic [CW-1:0] RAS_LAST = CW'(T_RAS - 1);
   localparam logic [CW-1:0] RP_LAST  = CW'(T_RP - 1);

   ref_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ras_q, ras_d;
   logic [3:0]    cas_q, cas_d;
   logic          complete;
   logic          urgent;
   logic          tick;

   refresh_timer #(
      .REF_INTERVAL (REF_INTERVAL),
      .MAX_PENDING  (MAX_PENDING)
   ) u_timer (
      .clk_i      (clkcpu_i),
      .rst_ni     (reset_ni),
      .complete_i (complete),
      .tick_o     (tick),
      .pending_o  (pending_o),
      .urgent_o   (urgent),
      .overrun_o  (overrun_o)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Only start between fastmem cycles; unless urgent, leave a
            // pending fast-RAM access alone.
            if ((pending_o != 3'd0) && ram_idle_i && (urgent || as20_i || ram_sel_i)) begin
               state_d = CSR;
            end
         end
         CSR: begin
            state_d = RAS;
            cnt_d   = '0;
         end
         RAS: begin
            if (cnt_q == RAS_LAST) begin
               state_d = PRE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRE: begin
            if (cnt_q == RP_LAST) begin
               state_d  = IDLE;
               complete = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Strobes are registered from the next state so they line up with
      // state_q and never glitch.
      ras_d = (state_d == RAS) ? 2'b00 : RAS_IDLE;
      cas_d = ((state_d == CSR) || (state_d == RAS)) ? 4'h0 : CAS_IDLE;
   end

   always_ff @(posedge clkcpu_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ras_q   <= RAS_IDLE;
         cas_q   <= CAS_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ras_q   <= ras_d;
         cas_q   <= cas_d;
      end
   end

   assign ref_ras_o    = ras_q;
   assign ref_cas_o    = cas_q;
   assign ref_active_o = (state_q != IDLE);
   assign cpu_hold_o   = ref_active_o | urgent;

endmodule
